pipe_stall_sched: RTL and testbench

//  Central stall scheduler for the 5-stage pipeline. Merges stall requests from the ID stage
//  (load-use), the EX stage (multi-cycle mul/div unit) and the MEM stage (data SRAM wait).

---
 rtl/pipe_stall_sched.sv | 105 ++++++++++
 tb/tb_pipe_stall_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_sched.sv
// Central stall scheduler: merges ID/EX/MEM stall requests into the StallBus by priority
// and sequences the shared multi-cycle mul/div unit (latency count, completion, misuse flag).
module pipe_stall_sched #(
    parameter int DIV_CYCLES = 33,
    parameter int MUL_CYCLES = 2,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id,
    input  logic       stallreq_mem,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic [5:0] stall,
    output logic       md_busy,
    output logic       md_done,
    output logic       md_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_MD   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic             md_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // The unit keeps counting under a MEM freeze; only DONE waits for MEM to release.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg | (md_start && (state_reg != IDLE));
        md_stall   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (md_start) begin
                    md_stall   = 1'b1;
                    cnt_next   = md_is_div ? DIV_LOAD : MUL_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                md_stall = 1'b1;
                if (cnt_reg == CNT_ONE) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            DONE: begin
                if (!stallreq_mem) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Strict priority select; the patterns are never OR-merged.
    always_comb begin
        stall = STALL_NONE;
        if (!rst) begin
            if (stallreq_mem) begin
                stall = STALL_MEM;
            end else if (md_stall) begin
                stall = STALL_MD;
            end else if (stallreq_id) begin
                stall = STALL_ID;
            end
        end
    end

    assign md_busy = !rst && (state_reg != IDLE);
    assign md_done = !rst && (state_reg == DONE);
    assign md_err  = err_reg;

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Directed bench for pipe_stall_sched: a per-cycle vector table for short sequences plus
// hand-written loops for the long divide, restart-misuse and mid-sequence reset cases.
module tb_pipe_stall_sched;

    logic       clk;
    logic       rst;
    logic       stallreq_id;
    logic       stallreq_mem;
    logic       md_start;
    logic       md_is_div;
    logic [5:0] stall;
    logic       md_busy;
    logic       md_done;
    logic       md_err;

    int n_vec  = 0;
    int n_miss = 0;

    pipe_stall_sched dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .stall        (stall),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .md_err       (md_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       id;
        logic       mem;
        logic       start;
        logic       is_div;
        logic [5:0] exp_stall;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    vec_t vecs[21];

    task automatic drive(input logic r, input logic id, input logic mem,
                         input logic st, input logic dv);
        rst          = r;
        stallreq_id  = id;
        stallreq_mem = mem;
        md_start     = st;
        md_is_div    = dv;
    endtask

    task automatic check(input string name, input logic [5:0] es, input logic eb,
                         input logic ed, input logic ee);
        n_vec++;
        if (stall !== es || md_busy !== eb || md_done !== ed || md_err !== ee) begin
            n_miss++;
            $display("FAIL %s: got stall=%b busy=%b done=%b err=%b, want stall=%b busy=%b done=%b err=%b",
                     name, stall, md_busy, md_done, md_err, es, eb, ed, ee);
        end else begin
            $display("ok   %s: stall=%b busy=%b done=%b err=%b", name, stall, md_busy, md_done, md_err);
        end
    endtask

    // Inputs are driven 1 ns after the edge; outputs are sampled 2 ns later, well before the next edge.
    task automatic settle;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst id mem st div  stall      busy done err
        vecs[0]  = '{1, 1, 1, 1, 1, 6'b000000, 0, 0, 0};   // reset with all requests high
        vecs[1]  = '{1, 1, 1, 1, 1, 6'b000000, 0, 0, 0};
        vecs[2]  = '{1, 1, 1, 1, 1, 6'b000000, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 6'b000111, 0, 0, 0};   // ID pulse
        vecs[5]  = '{0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 1, 0, 6'b001111, 0, 0, 0};   // mul start T
        vecs[7]  = '{0, 0, 1, 0, 0, 6'b011111, 1, 0, 0};   // T+1 MEM wins
        vecs[8]  = '{0, 0, 1, 0, 0, 6'b011111, 1, 1, 0};   // T+2 DONE held
        vecs[9]  = '{0, 0, 1, 0, 0, 6'b011111, 1, 1, 0};
        vecs[10] = '{0, 0, 1, 0, 0, 6'b011111, 1, 1, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 6'b000000, 1, 1, 0};   // T+5 released
        vecs[12] = '{0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};   // T+6 IDLE
        vecs[13] = '{0, 0, 1, 1, 0, 6'b011111, 0, 0, 0};   // start under MEM accepted
        vecs[14] = '{0, 0, 0, 0, 0, 6'b001111, 1, 0, 0};
        vecs[15] = '{0, 1, 0, 0, 0, 6'b000111, 1, 1, 0};   // DONE drops md_stall, ID visible
        vecs[16] = '{0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
        vecs[17] = '{0, 1, 0, 1, 0, 6'b001111, 0, 0, 0};   // ID masked by md_stall
        vecs[18] = '{0, 1, 0, 0, 0, 6'b001111, 1, 0, 0};
        vecs[19] = '{0, 1, 0, 0, 0, 6'b000111, 1, 1, 0};
        vecs[20] = '{0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};

        drive(1, 1, 1, 1, 1);
        tick();

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].id, vecs[i].mem, vecs[i].start, vecs[i].is_div);
            settle();
            check($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_busy,
                  vecs[i].exp_done, vecs[i].exp_err);
            tick();
        end

        // Divide with a stray restart at T+5: latency unchanged, md_err sticky.
        for (int k = 0; k <= 34; k++) begin
            drive(0, 0, 0, (k == 0 || k == 5), (k == 0));
            settle();
            if (k <= 32)
                check($sformatf("div T+%0d", k), 6'b001111, (k != 0), 1'b0, (k > 5));
            else if (k == 33)
                check("div T+33", 6'b000000, 1'b1, 1'b1, 1'b1);
            else
                check("div T+34", 6'b000000, 1'b0, 1'b0, 1'b1);
            tick();
        end

        drive(1, 0, 0, 1, 0);
        settle();
        check("err rst", 6'b000000, 1'b0, 1'b0, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0);
        settle();
        check("err cleared", 6'b000000, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset at T+10 of a divide, then a normal multiply.
        for (int k = 0; k <= 9; k++) begin
            drive(0, 0, 0, (k == 0), 1'b1);
            settle();
            if (k == 0 || k == 9)
                check($sformatf("abort div T+%0d", k), 6'b001111, (k != 0), 1'b0, 1'b0);
            tick();
        end
        drive(1, 1, 0, 0, 0);
        settle();
        check("abort rst T+10", 6'b000000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0);
        settle();
        check("abort T+11 idle", 6'b000000, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 0, 1, 0);
        settle();
        check("post-rst mul T", 6'b001111, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0);
        settle();
        check("post-rst mul T+1", 6'b001111, 1'b1, 1'b0, 1'b0);
        tick();
        settle();
        check("post-rst mul T+2", 6'b000000, 1'b1, 1'b1, 1'b0);
        tick();
        settle();
        check("post-rst mul T+3", 6'b000000, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
